// File: rtl/disp_pkg.sv
// Shared encodings for the display scheduler: mode codes, FSM states,
// digit indices and the per-digit blink mask helper.
package disp_pkg;

  localparam int unsigned TIME_W   = 20;
  localparam int unsigned STATE_W  = 6;
  localparam int unsigned MODE_W   = 3;
  localparam int unsigned DIGITS   = 6;

  // Mode encodings as presented by the mode controller
  localparam logic [MODE_W-1:0] MODE_IDLE   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SET    = 3'd1;
  localparam logic [MODE_W-1:0] MODE_ALARM  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_COUNT  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SELECT = 3'd4;

  // Low three bits of the state word for the special display pages
  localparam logic [2:0] PAGE_ALARM  = 3'd2;
  localparam logic [2:0] PAGE_SELECT = 3'd4;
  localparam logic [2:0] PAGE_BANNER = 3'd4;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_BANNER = 2'd1,
    ST_RING   = 2'd2
  } sched_state_e;

  // Digit positions inside the packed BCD time word
  localparam int unsigned DIG_SU = 0;
  localparam int unsigned DIG_ST = 1;
  localparam int unsigned DIG_MU = 2;
  localparam int unsigned DIG_MT = 3;
  localparam int unsigned DIG_HU = 4;
  localparam int unsigned DIG_HT = 5;

  // Any set_pos at or above this value selects no digit
  localparam logic [2:0] SET_POS_NONE = 3'd6;

  // One-hot blink mask: bit[pos] follows 'on', everything else lit
  function automatic logic [DIGITS-1:0] digit_mask(input logic [2:0] pos, input logic on);
    logic [DIGITS-1:0] m;
    m = '0;
    if (pos < SET_POS_NONE) begin
      m[DIG_SU] = on & (pos == 3'(DIG_SU));
      m[DIG_ST] = on & (pos == 3'(DIG_ST));
      m[DIG_MU] = on & (pos == 3'(DIG_MU));
      m[DIG_MT] = on & (pos == 3'(DIG_MT));
      m[DIG_HU] = on & (pos == 3'(DIG_HU));
      m[DIG_HT] = on & (pos == 3'(DIG_HT));
    end
    return m;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink timebase: free-running 0..BLINK_DIV-1 counter whose wrap toggles a
// phase bit. A synchronous clear restarts both counter and phase at 0.
// phase_nxt_c exposes the phase value that will be held after this edge so
// registered consumers can stay aligned with it.
module blink_gen #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clk_sys,
  input  logic rstn,
  input  logic clr,
  output logic wrap_c,
  output logic phase_nxt_c
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;

  assign wrap_c      = (cnt == CNT_MAX);
  assign phase_nxt_c = clr ? 1'b0 : (phase ^ wrap_c);

  // Counter and phase register
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      phase <= phase_nxt_c;
      if (clr || wrap_c) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: picks the time source and state word for the
// seven-segment driver, overlays a timed banner on mode changes and a
// flashing alarm-ring page, and produces the per-digit blank mask.
// All outputs are registered from the next-state view of the FSM, so they
// reflect the inputs sampled on the previous clk_sys edge.
// Build option: define SCHED_RING_TIMEOUT_EN to let an unacknowledged ring
// clear itself after RING_PERIODS blink half-periods.
module disp_sched
  import disp_pkg::*;
#(
  parameter int unsigned BLINK_DIV    = 25000000,
  parameter int unsigned BANNER_CYC   = 50000000,
  parameter int unsigned RING_PERIODS = 60
) (
  input  logic        clk_sys,
  input  logic        rstn,
  input  logic [2:0]  mode,
  input  logic [2:0]  sel_mode,
  input  logic [1:0]  alm_flags,
  input  logic [19:0] clk_time,
  input  logic [19:0] set_time,
  input  logic [19:0] alm_time,
  input  logic [19:0] cnt_time,
  input  logic [2:0]  set_pos,
  input  logic        ring_req,
  input  logic        ring_ack,
  output logic [19:0] disp_data,
  output logic [5:0]  disp_state,
  output logic [5:0]  disp_blank,
  output logic        ring_active
);

  localparam int unsigned BAN_W = (BANNER_CYC > 1) ? $clog2(BANNER_CYC) : 1;
  localparam logic [BAN_W-1:0] BAN_LOAD = BAN_W'(BANNER_CYC - 1);

  sched_state_e        state;
  sched_state_e        state_nxt;
  logic [MODE_W-1:0]   last_mode;
  logic                ring_req_q;
  logic [BAN_W-1:0]    ban_cnt;

  logic                ban_load_c;
  logic                ring_edge_c;
  logic                mode_chg_c;
  logic                ring_timeout_c;
  logic                blink_clr_c;
  logic                blink_wrap_c;
  logic                phase_nxt_c;

  logic [TIME_W-1:0]   data_d;
  logic [STATE_W-1:0]  state_d;
  logic [DIGITS-1:0]   blank_d;
  logic                ring_d;

  assign ring_edge_c = ring_req & ~ring_req_q;
  assign mode_chg_c  = (mode != last_mode);
  // Blink restarts on ring entry so the first half-period is visible
  assign blink_clr_c = (state_nxt == ST_RING) && (state != ST_RING);

  blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk_sys     (clk_sys),
    .rstn        (rstn),
    .clr         (blink_clr_c),
    .wrap_c      (blink_wrap_c),
    .phase_nxt_c (phase_nxt_c)
  );

`ifdef SCHED_RING_TIMEOUT_EN
  localparam int unsigned RP_W = (RING_PERIODS > 1) ? $clog2(RING_PERIODS) : 1;
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(RING_PERIODS - 1);

  logic [RP_W-1:0] ring_per;

  // Count blink half-periods spent ringing
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn)                  ring_per <= '0;
    else if (state != ST_RING)  ring_per <= '0;
    else if (blink_wrap_c)      ring_per <= ring_per + 1'b1;
  end

  // Timeout fires on the toggle that completes the last half-period
  assign ring_timeout_c = (state == ST_RING) && blink_wrap_c && (ring_per == RP_LAST);
`else
  logic unused_ring_periods;
  assign unused_ring_periods = (RING_PERIODS != 0);
  assign ring_timeout_c      = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) state <= ST_NORMAL;
    else       state <= state_nxt;
  end

  // Mode tracking, ring edge detect and banner countdown
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      last_mode  <= MODE_IDLE;
      ring_req_q <= 1'b0;
      ban_cnt    <= '0;
    end else begin
      last_mode  <= mode;
      ring_req_q <= ring_req;
      if (ban_load_c)                                   ban_cnt <= BAN_LOAD;
      else if ((state == ST_BANNER) && (ban_cnt != '0)) ban_cnt <= ban_cnt - 1'b1;
    end
  end

  // Next-state: RING beats BANNER beats NORMAL; ack suppresses a same-cycle edge
  always_comb begin
    state_nxt  = state;
    ban_load_c = 1'b0;
    case (state)
      ST_NORMAL, ST_BANNER: begin
        if (ring_edge_c && !ring_ack && (mode != MODE_SET)) begin
          state_nxt = ST_RING;
        end else if (mode_chg_c && (mode != MODE_SELECT)) begin
          state_nxt  = ST_BANNER;
          ban_load_c = 1'b1;
        end else if ((state == ST_BANNER) && (ban_cnt == '0)) begin
          state_nxt = ST_NORMAL;
        end
      end
      ST_RING: begin
        if (ring_ack || !ring_req || ring_timeout_c) state_nxt = ST_NORMAL;
      end
      default: state_nxt = ST_NORMAL;
    endcase
  end

  // Output decode from the state being entered on this edge
  always_comb begin
    data_d  = '0;
    state_d = '0;
    blank_d = '0;
    ring_d  = 1'b0;
    case (state_nxt)
      ST_NORMAL: begin
        case (mode)
          MODE_IDLE:  data_d = clk_time;
          MODE_SET:   data_d = set_time;
          MODE_ALARM: data_d = alm_time;
          MODE_COUNT: data_d = cnt_time;
          default:    data_d = '0;
        endcase
        if (mode == MODE_SELECT)     state_d = {sel_mode, PAGE_SELECT};
        else if (mode == MODE_ALARM) state_d = {1'b0, alm_flags, PAGE_ALARM};
        else                         state_d = {3'd0, mode};
        if ((mode == MODE_SET) || (mode == MODE_ALARM)) blank_d = digit_mask(set_pos, phase_nxt_c);
      end
      ST_BANNER: begin
        state_d = {mode, PAGE_BANNER};
      end
      ST_RING: begin
        data_d  = alm_time;
        blank_d = {DIGITS{phase_nxt_c}};
        ring_d  = 1'b1;
      end
      default: begin
        data_d = '0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      disp_data   <= '0;
      disp_state  <= '0;
      disp_blank  <= '0;
      ring_active <= 1'b0;
    end else begin
      disp_data   <= data_d;
      disp_state  <= state_d;
      disp_blank  <= blank_d;
      ring_active <= ring_d;
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with BLINK_DIV=4, BANNER_CYC=10, RING_PERIODS=6.
module tb_disp_sched;

  logic        clk_sys = 1'b0;
  logic        rstn    = 1'b0;
  logic [2:0]  mode;
  logic [2:0]  sel_mode;
  logic [1:0]  alm_flags;
  logic [19:0] clk_time;
  logic [19:0] set_time;
  logic [19:0] alm_time;
  logic [19:0] cnt_time;
  logic [2:0]  set_pos;
  logic        ring_req;
  logic        ring_ack;
  logic [19:0] disp_data;
  logic [5:0]  disp_state;
  logic [5:0]  disp_blank;
  logic        ring_active;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  disp_sched #(
    .BLINK_DIV    (4),
    .BANNER_CYC   (10),
    .RING_PERIODS (6)
  ) dut (
    .clk_sys     (clk_sys),
    .rstn        (rstn),
    .mode        (mode),
    .sel_mode    (sel_mode),
    .alm_flags   (alm_flags),
    .clk_time    (clk_time),
    .set_time    (set_time),
    .alm_time    (alm_time),
    .cnt_time    (cnt_time),
    .set_pos     (set_pos),
    .ring_req    (ring_req),
    .ring_ack    (ring_ack),
    .disp_data   (disp_data),
    .disp_state  (disp_state),
    .disp_blank  (disp_blank),
    .ring_active (ring_active)
  );

  always #5 clk_sys = ~clk_sys;

  // Clock edges since reset release, used to predict the blink phase
  always @(posedge clk_sys or negedge rstn) begin
    if (!rstn) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic chk20(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    mode      = 3'd0;
    sel_mode  = 3'd0;
    alm_flags = 2'b00;
    clk_time  = 20'h12345;
    set_time  = 20'h23456;
    alm_time  = 20'h07300;
    cnt_time  = 20'h01500;
    set_pos   = 3'd7;
    ring_req  = 1'b0;
    ring_ack  = 1'b0;

    // Reset values
    tick(2);
    chk20("rst_data", disp_data, 20'h0);
    chk6 ("rst_state", disp_state, 6'd0);
    chk6 ("rst_blank", disp_blank, 6'd0);
    chk1 ("rst_ring", ring_active, 1'b0);
    rstn = 1'b1;

    // IDLE shows clk_time one cycle later, no banner
    tick(1);
    chk20("idle_data", disp_data, 20'h12345);
    chk6 ("idle_state", disp_state, 6'd0);
    chk6 ("idle_blank", disp_blank, 6'd0);
    tick(2);
    chk6 ("idle_nobanner", disp_state, 6'd0);

    // IDLE -> COUNT: banner for exactly 10 cycles
    mode = 3'd3;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk6 ("cnt_banner_state", disp_state, 6'b011100);
      chk20("cnt_banner_data", disp_data, 20'h0);
    end
    tick(1);
    chk6 ("cnt_state", disp_state, 6'd3);
    chk20("cnt_data", disp_data, 20'h01500);

    // COUNT -> SET with digit 2 under edit
    mode    = 3'd1;
    set_pos = 3'd2;
    tick(1);
    chk6 ("set_banner_state", disp_state, 6'b001100);
    chk6 ("set_banner_blank", disp_blank, 6'd0);
    tick(9);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk6 ("set_blank", disp_blank, (((edges / 4) % 2) == 1) ? 6'b000100 : 6'b000000);
    end
    chk6 ("set_state", disp_state, 6'd1);
    chk20("set_data", disp_data, 20'h23456);
    set_pos = 3'd7;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk6 ("set_nopos_blank", disp_blank, 6'd0);
    end

    // SET -> ALARM: state word carries alm_flags
    mode      = 3'd2;
    alm_flags = 2'b10;
    tick(11);
    chk6 ("alarm_state", disp_state, 6'b010010);
    chk20("alarm_data", disp_data, 20'h07300);

    // Back to IDLE, then ring with blinking page
    mode = 3'd0;
    tick(11);
    chk6 ("idle2_state", disp_state, 6'd0);
    ring_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk1 ("ring_active", ring_active, 1'b1);
      chk20("ring_data", disp_data, 20'h07300);
      chk6 ("ring_state", disp_state, 6'd0);
      chk6 ("ring_blank", disp_blank, (((i / 4) % 2) == 1) ? 6'h3F : 6'h00);
    end
    ring_ack = 1'b1;
    tick(1);
    ring_ack = 1'b0;
    chk1 ("ack_ring", ring_active, 1'b0);
    chk20("ack_data", disp_data, 20'h12345);
    tick(1);
    chk1 ("ack_no_reentry", ring_active, 1'b0);
    ring_req = 1'b0;
    tick(1);

    // Ring edge during a banner aborts it
    mode = 3'd3;
    tick(3);
    chk6 ("abort_banner_state", disp_state, 6'b011100);
    ring_req = 1'b1;
    tick(1);
    chk1 ("abort_ring", ring_active, 1'b1);
    chk6 ("abort_state", disp_state, 6'd0);
    chk20("abort_data", disp_data, 20'h07300);
    ring_ack = 1'b1;
    tick(1);
    ring_ack = 1'b0;
    chk1 ("abort_ack_ring", ring_active, 1'b0);
    chk6 ("abort_ack_state", disp_state, 6'd3);
    chk20("abort_ack_data", disp_data, 20'h01500);
    ring_req = 1'b0;

    // Ring edge in SET is ignored
    mode = 3'd1;
    tick(11);
    chk6 ("set2_state", disp_state, 6'd1);
    ring_req = 1'b1;
    tick(1);
    chk1 ("set_ring_ignored", ring_active, 1'b0);
    tick(2);
    chk1 ("set_ring_ignored2", ring_active, 1'b0);
    chk6 ("set_ring_state", disp_state, 6'd1);
    ring_req = 1'b0;

    // SELECT shows sel_mode with no banner
    mode     = 3'd4;
    sel_mode = 3'd5;
    tick(1);
    chk6 ("select_state", disp_state, 6'b101100);
    chk20("select_data", disp_data, 20'h0);
    mode = 3'd0;
    tick(1);
    chk6 ("unselect_banner", disp_state, 6'b000100);
    tick(10);
    chk6 ("idle3_state", disp_state, 6'd0);

    // Unacknowledged ring
    ring_req = 1'b1;
`ifdef SCHED_RING_TIMEOUT_EN
    for (int i = 0; i < 24; i++) begin
      tick(1);
      chk1 ("to_ring_held", ring_active, 1'b1);
    end
    tick(1);
    chk1 ("to_ring_exit", ring_active, 1'b0);
    chk20("to_exit_data", disp_data, 20'h12345);
`else
    for (int i = 0; i < 100; i++) begin
      if (i == 50) mode = 3'd3;
      tick(1);
      if ((i % 10) == 0 || i == 99) chk1 ("ring_held", ring_active, 1'b1);
      if (i == 60) chk6 ("ring_mode_absorbed", disp_state, 6'd0);
    end
`endif
    ring_req = 1'b0;
    tick(1);
    chk1 ("req_low_exit", ring_active, 1'b0);
    chk6 ("req_low_state", disp_state, {3'd0, mode});

    // Async reset in the middle of a ring
    ring_req = 1'b1;
    tick(1);
    chk1 ("ring_again", ring_active, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk20("arst_data", disp_data, 20'h0);
    chk6 ("arst_state", disp_state, 6'd0);
    chk6 ("arst_blank", disp_blank, 6'd0);
    chk1 ("arst_ring", ring_active, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
